// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder with programmable latency over a byte-lane word array
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_fun3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  logic          lat_load, lat_store;
  logic [2:0]    lat_fun3;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;

  logic          accept, fire, req_err, we;
  logic [AW-1:0] word_idx;
  logic [3:0]    be;
  logic [31:0]   wdata_lane, rd_word, rd_shift, load_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  logic [31:0]   mem [DEPTH_WORDS];

  // Address bits above the array size are ignored so accesses wrap.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign req_ready  = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign fire       = (state == WAIT) && (cnt == '0);
  assign word_idx   = lat_addr[AW+1:2];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept, count down the latency, one response cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request at acceptance and run the latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lat_load  <= 1'b0;
      lat_store <= 1'b0;
      lat_fun3  <= 3'b000;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      cnt       <= CW'(LATENCY - 1);
      lat_load  <= req_load;
      lat_store <= req_store;
      lat_fun3  <= req_fun3;
      lat_addr  <= req_addr[AW+1:0];
      lat_wdata <= req_wdata;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Reject malformed opcodes, illegal width codes and misaligned accesses.
  always_comb begin
    req_err = 1'b0;
    if (lat_load == lat_store)
      req_err = 1'b1;
    else if (lat_store && (lat_fun3[2] || lat_fun3[1:0] == 2'b11))
      req_err = 1'b1;
    else if (lat_load && (lat_fun3[1:0] == 2'b11 || lat_fun3 == 3'b110))
      req_err = 1'b1;
    else if (lat_fun3[1:0] == 2'b01 && lat_addr[0])
      req_err = 1'b1;
    else if (lat_fun3[1:0] == 2'b10 && lat_addr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  // Byte enables and replicated store data for the addressed lanes.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = lat_wdata;
    case (lat_fun3[1:0])
      2'b00: begin
        be         = 4'b0001 << lat_addr[1:0];
        wdata_lane = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be         = lat_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{lat_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // A reset arriving on the commit edge suppresses the write.
  assign we = fire && lat_store && !req_err && !rst;

  // Word array with per-lane writes; contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
  end

  // Lane select and sign/zero extension of the read word.
  always_comb begin
    rd_word   = mem[word_idx];
    rd_shift  = rd_word >> {lat_addr[1:0], 3'b000};
    byte_sel  = rd_shift[7:0];
    half_sel  = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    case (lat_fun3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      3'b010:  load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  // Response registers update only on the commit edge and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (fire) begin
      resp_err   <= req_err;
      resp_rdata <= (lat_load && !req_err) ? load_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;
  localparam int NBYTES      = DEPTH_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_fun3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mbytes [NBYTES];

  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_err(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (ld == st) return 1'b1;
    if (st && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 1'b1;
    if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (a % m_size(f3) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int     base = int'(a % NBYTES);
    int     n    = m_size(f3);
    longint val  = 0;
    for (int i = 0; i < n; i++) val += longint'(mbytes[base + i]) << (8 * i);
    if (f3 < 4 && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
    return val[31:0];
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int base = int'(a % NBYTES);
    for (int i = 0; i < m_size(f3); i++) mbytes[base + i] = wd[8*i +: 8];
  endtask

  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    bit          exp_er;
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_fun3 = f3; req_addr = a; req_wdata = wd;
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    exp_er = m_err(ld, st, f3, a);
    exp_rd = 32'h0;
    if (!exp_er && ld) exp_rd = m_load(f3, a);
    if (!exp_er && st) m_store(f3, a, wd);
    @(negedge clk);
    for (int k = 1; k <= LATENCY + 1; k++) begin
      if (k > 1) @(negedge clk);
      check("ready_busy", {31'b0, req_ready}, 32'd0);
      check("busy", {31'b0, busy}, 32'd1);
      check("resp_valid", {31'b0, resp_valid}, (k == LATENCY + 1) ? 32'd1 : 32'd0);
      if (k < LATENCY + 1) begin
        req_valid = 1'($urandom); req_load = 1'($urandom); req_store = 1'($urandom);
        req_fun3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end
    rd = resp_rdata;
    er = resp_err;
    check("rdata", rd, exp_rd);
    check("err", {31'b0, er}, {31'b0, exp_er});
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          r;
    bit          ld, st;

    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_fun3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;

    for (int w = 0; w < 64; w++) do_req(1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom, rd, er);

    do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er);
    check("sw_err", {31'b0, er}, 32'd0);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);

    do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'h0, rd, er);
    do_req(1'b0, 1'b1, 3'd0, 32'h11, 32'h80, rd, er);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check("sb_word", rd, 32'h00008000);
    do_req(1'b1, 1'b0, 3'd0, 32'h11, 32'h0, rd, er);
    check("lb", rd, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, 3'd4, 32'h11, 32'h0, rd, er);
    check("lbu", rd, 32'h00000080);

    do_req(1'b0, 1'b1, 3'd2, 32'h20, 32'h11112222, rd, er);
    do_req(1'b0, 1'b1, 3'd1, 32'h22, 32'h00008001, rd, er);
    do_req(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, rd, er);
    check("lh", rd, 32'hFFFF8001);
    do_req(1'b1, 1'b0, 3'd5, 32'h22, 32'h0, rd, er);
    check("lhu", rd, 32'h00008001);
    do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    check("sh_word", rd, 32'h80012222);

    do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D, rd, er);
    do_req(1'b1, 1'b0, 3'd2, 32'h13, 32'h0, rd, er);
    check("mis_lw_err", {31'b0, er}, 32'd1);
    do_req(1'b0, 1'b1, 3'd1, 32'h15, 32'hFFFFFFFF, rd, er);
    check("mis_sh_err", {31'b0, er}, 32'd1);
    do_req(1'b1, 1'b0, 3'd6, 32'h10, 32'h0, rd, er);
    check("bad_f3_err", {31'b0, er}, 32'd1);
    do_req(1'b1, 1'b1, 3'd2, 32'h10, 32'h12345678, rd, er);
    check("ldst_err", {31'b0, er}, 32'd1);
    check("ldst_rdata", rd, 32'h0);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check("err_nowrite", rd, 32'hCAFEF00D);
    do_req(1'b1, 1'b0, 3'd2, 32'h14, 32'h0, rd, er);

    do_req(1'b0, 1'b1, 3'd2, 32'h1004, 32'h12345678, rd, er);
    do_req(1'b1, 1'b0, 3'd2, 32'h4, 32'h0, rd, er);
    check("wrap", rd, 32'h12345678);

    do_req(1'b0, 1'b1, 3'd2, 32'h30, 32'hA5A55A5A, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_fun3 = 3'd2; req_addr = 32'h30; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", {31'b0, req_ready}, 32'd0);
    check("abort_busy_rst", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_noresp", {31'b0, resp_valid}, 32'd0);
    end
    do_req(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, rd, er);
    check("abort_nowrite", rd, 32'hA5A55A5A);

    for (int it = 0; it < 300; it++) begin
      r = int'($urandom % 8);
      if (r == 0)      begin ld = 1'b0; st = 1'b0; end
      else if (r == 1) begin ld = 1'b1; st = 1'b1; end
      else if (r < 5)  begin ld = 1'b1; st = 1'b0; end
      else             begin ld = 1'b0; st = 1'b1; end
      do_req(ld, st, 3'($urandom), $urandom & 32'hFFFF_F0FF, $urandom, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far side of the core's load/store request path.
- Accepts one load or store per handshake, carrying the funct3 width code and a byte address.
- Performs a byte-lane-aligned access to an internal word array after a fixed programmable latency.
- Returns sign- or zero-extended load data, or flags an error, on a one-cycle response pulse.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- LATENCY, 2, cycles from the acceptance edge to the response cycle; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request; high only in IDLE with rst low.
- req_load  input  1  request is a load.
- req_store  input  1  request is a store.
- req_fun3  input  3  width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; bytes are taken from the low end.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  request was rejected; qualified by resp_valid.
- busy  output  1  high in WAIT or RESP.

Behaviour:
- State machine states: IDLE, WAIT, RESP.
- Reset: state goes to IDLE. resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=0 while rst is high. The latched request and counter are cleared. Array contents are not reset.
- Accept: in IDLE, on a rising edge with req_valid=1 and req_ready=1, the responder latches load, store, fun3, addr and wdata. It sets cnt=LATENCY-1 and goes to WAIT.
- WAIT: cnt decrements each edge. On the edge where cnt==0 the access executes and state goes to RESP.
- RESP: lasts exactly one cycle, with resp_valid=1 and busy=1. On the next edge state returns to IDLE.
- Timing: with acceptance in cycle N, resp_valid is high in cycle N+LATENCY+1. The next request can be accepted in cycle N+LATENCY+2. req_ready is low in WAIT and RESP.
- Error checks (evaluated on the latched request):
  - load and store both 1, or both 0;
  - store with fun3 not in {000,001,010};
  - load with fun3 in {011,110,111};
  - half access with addr[0]=1;
  - word access with addr[1:0]!=00.
- On error: no array write, resp_err=1, resp_rdata=0.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Store b: writes wdata[7:0] into byte lane addr[1:0].
- Store h: writes wdata[15:0] into lanes {addr[1],0}+1 down to {addr[1],0}.
- Store w: writes all 4 lanes.
- Other lanes are untouched. The store commits on the WAIT->RESP edge. resp_rdata=0, resp_err=0.
- Load: the word is read at the WAIT->RESP edge, then lane-selected and extended into a registered resp_rdata.
  - b: sign-extend the selected byte;
  - bu: zero-extend the selected byte;
  - h: sign-extend the selected half;
  - hu: zero-extend the selected half;
  - w: the full word.
- Little-endian: lane 0 is bits 7:0.
- Request inputs are ignored outside IDLE; they are sampled only at acceptance.
- Reset mid-operation: an asserted rst in WAIT aborts the request. No write occurs unless the WAIT->RESP edge has already passed. No response is issued.
- resp_rdata and resp_err hold their values outside RESP. They are meaningful only while resp_valid=1.

Test Plan:
- After reset, store w addr 0x10 data 0xDEADBEEF, then load w addr 0x10, LATENCY=2 -> store resp in accept+3 with err=0; load returns 0xDEADBEEF; req_ready low for 3 cycles after each accept.
- Store b 0x80 at addr 0x11 over word 0x00000000, then load b 0x11 and load bu 0x11 -> word becomes 0x00008000; loads return 0xFFFFFF80 and 0x00000080.
- Store h 0x8001 at addr 0x22, then load h 0x22 and load hu 0x22 -> 0xFFFF8001 and 0x00008001; the lower half of word 0x20 is unchanged.
- Load w at addr 0x13, store h at addr 0x15, load fun3=110, load=store=1 -> each gives resp_err=1 and resp_rdata=0; the array is unchanged, checked by a following load w.
- DEPTH_WORDS=1024: store w 0x12345678 at addr 0x1004, then load w addr 0x4 -> returns 0x12345678, confirming wrap.
- Accept store w addr 0x30 data 0x55, assert rst one cycle later in WAIT -> no resp_valid; after reset, load w 0x30 returns the prior contents, not 0x55.
